// File: rtl/multicycle_main_decoder.sv
// Multi-cycle RISC-V main decoder: FETCH/DECODE/EXEC/MEM/WB sequencer with cache stall timeout.
// Optional JAL support is enabled by defining JAL_EN (adds the Jump output).
module multicycle_main_decoder #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = $clog2(TIMEOUT_CYC),
    parameter int unsigned IMMSRC_W    = 2,
    parameter int unsigned ALUOP_W     = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Instr_Valid,
    input  logic [6:0]          Decoder_Input,
    input  logic                Stall,
    output logic                Instr_Ready,
    output logic [IMMSRC_W-1:0] ImmSrc,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOp_MD,
    output logic                ResultSrc,
    output logic                Branch,
    output logic                MemWrite,
    output logic                MemReadCpu,
    output logic                RegWrite,
    output logic                Busy,
    output logic                Illegal,
`ifdef JAL_EN
    output logic                Jump,
`endif
    output logic                Timeout
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
    typedef enum logic [2:0] {ClsNone, ClsLw, ClsSw, ClsR, ClsI, ClsBr, ClsJal} cls_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT_CYC - 1);

    state_e           r_state;
    cls_e             r_cls;
    logic [CNT_W-1:0] r_cnt;
    logic             r_illegal;
    logic             r_timeout;

    cls_e             w_cls_in;
    logic [1:0]       w_imm;
    logic [1:0]       w_aluop;
    logic             w_fetch;

    always_comb begin
        w_cls_in = ClsNone;
        unique case (Decoder_Input)
            7'b0000011: w_cls_in = ClsLw;
            7'b0100011: w_cls_in = ClsSw;
            7'b0110011: w_cls_in = ClsR;
            7'b0010011: w_cls_in = ClsI;
            7'b1100011: w_cls_in = ClsBr;
`ifdef JAL_EN
            7'b1101111: w_cls_in = ClsJal;
`endif
            default:    w_cls_in = ClsNone;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= StFetch;
            r_cls     <= ClsNone;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            unique case (r_state)
                StFetch: begin
                    if (Instr_Valid) begin
                        r_cls   <= w_cls_in;
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    if (r_cls == ClsNone) begin
                        r_state   <= StFetch;
                        r_illegal <= 1'b1;
                    end else begin
                        r_state <= StExec;
                    end
                end
                StExec: begin
                    if (r_cls == ClsBr) begin
                        r_state <= StFetch;
                    end else if (r_cls == ClsLw || r_cls == ClsSw) begin
                        r_cnt   <= '0;
                        r_state <= StMem;
                    end else begin
                        r_state <= StWb;
                    end
                end
                StMem: begin
                    if (!Stall) begin
                        r_state <= (r_cls == ClsLw) ? StWb : StFetch;
                    end else if (r_cnt == CntMax) begin
                        // Stall outlasted the budget: abandon the request
                        r_state   <= StFetch;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StWb:    r_state <= StFetch;
                default: r_state <= StFetch;
            endcase
        end
    end

    assign w_fetch = (r_state == StFetch);

    always_comb begin
        w_imm  = 2'b00;
        w_aluop = 2'b00;
        ALUSrc = 1'b0;
        if (!w_fetch) begin
            unique case (r_cls)
                ClsLw:   ALUSrc = 1'b1;
                ClsSw:   begin w_imm = 2'b01; ALUSrc = 1'b1; end
                ClsR:    w_aluop = 2'b10;
                ClsI:    begin w_aluop = 2'b10; ALUSrc = 1'b1; end
                ClsBr:   begin w_imm = 2'b10; w_aluop = 2'b01; end
                ClsJal:  w_imm = 2'b11;
                default: w_imm = 2'b00;
            endcase
        end
    end

    // Reset forces FETCH, so only Instr_Ready needs explicit gating to stay low in reset
    assign Instr_Ready = w_fetch & RST;
    assign Busy        = !w_fetch;
    assign ImmSrc      = IMMSRC_W'(w_imm);
    assign ALUOp_MD    = ALUOP_W'(w_aluop);
    assign Branch      = (r_state == StExec) && (r_cls == ClsBr);
    assign MemReadCpu  = (r_state == StMem) && (r_cls == ClsLw);
    assign MemWrite    = (r_state == StMem) && (r_cls == ClsSw);
    assign RegWrite    = (r_state == StWb);
    assign ResultSrc   = (r_state == StWb) && (r_cls == ClsLw);
    assign Illegal     = r_illegal;
    assign Timeout     = r_timeout;
`ifdef JAL_EN
    assign Jump        = (r_state == StExec) && (r_cls == ClsJal);
`endif

endmodule

// File: tb/tb_multicycle_main_decoder.sv
// Directed, table-driven bench for multicycle_main_decoder (default build, TIMEOUT_CYC=16).
module tb_multicycle_main_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Instr_Valid = 1'b0;
    logic [6:0] Decoder_Input = 7'd0;
    logic       Stall = 1'b0;
    logic       Instr_Ready, ALUSrc, ResultSrc, Branch, MemWrite, MemReadCpu;
    logic       RegWrite, Busy, Illegal, Timeout;
    logic [1:0] ImmSrc, ALUOp_MD;
`ifdef JAL_EN
    logic       Jump;
`endif
    logic [13:0] all_outs;

    multicycle_main_decoder #(
        .TIMEOUT_CYC(16),
        .IMMSRC_W   (2),
        .ALUOP_W    (2)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .Instr_Valid  (Instr_Valid),
        .Decoder_Input(Decoder_Input),
        .Stall        (Stall),
        .Instr_Ready  (Instr_Ready),
        .ImmSrc       (ImmSrc),
        .ALUSrc       (ALUSrc),
        .ALUOp_MD     (ALUOp_MD),
        .ResultSrc    (ResultSrc),
        .Branch       (Branch),
        .MemWrite     (MemWrite),
        .MemReadCpu   (MemReadCpu),
        .RegWrite     (RegWrite),
        .Busy         (Busy),
        .Illegal      (Illegal),
`ifdef JAL_EN
        .Jump         (Jump),
`endif
        .Timeout      (Timeout)
    );

    assign all_outs = {Instr_Ready, ImmSrc, ALUSrc, ALUOp_MD, ResultSrc, Branch, MemWrite,
                       MemReadCpu, RegWrite, Busy, Illegal, Timeout};

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Cycle numbers count from the accept edge; 0 means "never seen"
    typedef struct {
        logic [6:0] op;
        int nstall;
        int imm;
        int alusrc;
        int aluop;
        int br_cyc;
        int rd_first;
        int rd_cnt;
        int wr_first;
        int wr_cnt;
        int rw_cyc;
        int rs;
        int ill_cyc;
        int to_cyc;
        int rdy_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        int imm1 = 0, src1 = 0, op1 = 0;
        int br_cyc = 0, br_cnt = 0, rd_first = 0, rd_cnt = 0, wr_first = 0, wr_cnt = 0;
        int rw_cyc = 0, rw_cnt = 0, rs = 0, ill = 0, to = 0, rdy = 0, mem_seen = 0, bad = 0;
        string t;
        t = $sformatf("v%0d", idx);
        for (int i = 0; i < 50 && !Instr_Ready; i++) @(negedge CLK);
        if (!Instr_Ready) begin
            check({t, "_ready_wait"}, 0, 1);
            return;
        end
        Instr_Valid   = 1'b1;
        Decoder_Input = v.op;
        @(posedge CLK);
        #1;
        Instr_Valid   = 1'b0;
        Decoder_Input = 7'b1111111;
        for (int cyc = 1; cyc <= 40 && rdy == 0; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                imm1 = int'(ImmSrc);
                src1 = int'(ALUSrc);
                op1  = int'(ALUOp_MD);
            end
            if (Instr_Ready) begin
                rdy = cyc;
                if (ImmSrc != 0 || ALUSrc || ALUOp_MD != 0 || Busy) bad++;
            end else if (!Busy || int'(ImmSrc) != imm1 || int'(ALUSrc) != src1 ||
                         int'(ALUOp_MD) != op1) begin
                bad++;
            end
            if (int'(Branch) + int'(MemWrite) + int'(MemReadCpu) + int'(RegWrite) > 1) bad++;
            if (Branch) begin br_cnt++; if (br_cyc == 0) br_cyc = cyc; end
            if (MemReadCpu) begin rd_cnt++; if (rd_first == 0) rd_first = cyc; end
            if (MemWrite) begin wr_cnt++; if (wr_first == 0) wr_first = cyc; end
            if (RegWrite) begin
                rw_cnt++;
                if (rw_cyc == 0) begin rw_cyc = cyc; rs = int'(ResultSrc); end
            end else if (ResultSrc) begin
                bad++;
            end
            if (Illegal && ill == 0) ill = cyc;
            if (Timeout && to == 0) to = cyc;
            if (MemReadCpu || MemWrite) begin
                mem_seen++;
                Stall = (mem_seen <= v.nstall);
            end else begin
                Stall = 1'b0;
            end
        end
        check({t, "_imm"}, imm1, v.imm);
        check({t, "_alusrc"}, src1, v.alusrc);
        check({t, "_aluop"}, op1, v.aluop);
        check({t, "_br_cyc"}, br_cyc, v.br_cyc);
        check({t, "_br_cnt"}, br_cnt, (v.br_cyc != 0) ? 1 : 0);
        check({t, "_rd_first"}, rd_first, v.rd_first);
        check({t, "_rd_cnt"}, rd_cnt, v.rd_cnt);
        check({t, "_wr_first"}, wr_first, v.wr_first);
        check({t, "_wr_cnt"}, wr_cnt, v.wr_cnt);
        check({t, "_rw_cyc"}, rw_cyc, v.rw_cyc);
        check({t, "_rw_cnt"}, rw_cnt, (v.rw_cyc != 0) ? 1 : 0);
        check({t, "_resultsrc"}, rs, v.rs);
        check({t, "_illegal_cyc"}, ill, v.ill_cyc);
        check({t, "_timeout_cyc"}, to, v.to_cyc);
        check({t, "_ready_cyc"}, rdy, v.rdy_cyc);
        check({t, "_per_cycle_rules"}, bad, 0);
    endtask

    initial begin
        int br_cyc, rw_cyc;
        //          op          nst imm src aop br rdF rdN wrF wrN rw rs ill to rdy
        vecs.push_back('{7'b0110011, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4});
        vecs.push_back('{7'b0010011, 0, 0, 1, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4});
        vecs.push_back('{7'b1100011, 0, 2, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 3});
        vecs.push_back('{7'b0000011, 0, 0, 1, 0, 0, 3, 1, 0, 0, 4, 1, 0, 0, 5});
        vecs.push_back('{7'b0000011, 3, 0, 1, 0, 0, 3, 4, 0, 0, 7, 1, 0, 0, 8});
        vecs.push_back('{7'b0100011, 0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 4});
        vecs.push_back('{7'b0100011, 2, 1, 1, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 6});
        vecs.push_back('{7'b0100011, 100, 1, 1, 0, 0, 0, 0, 3, 16, 0, 0, 0, 19, 19});
        vecs.push_back('{7'b0000011, 100, 0, 1, 0, 0, 3, 16, 0, 0, 0, 0, 0, 19, 19});
        vecs.push_back('{7'b0000011, 15, 0, 1, 0, 0, 3, 16, 0, 0, 19, 1, 0, 0, 20});
        vecs.push_back('{7'b1111111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2});
        vecs.push_back('{7'b0110011, 0, 0, 0, 2, 0, 0, 0, 0, 0, 3, 0, 0, 0, 4});
        vecs.push_back('{7'b0000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2});
`ifndef JAL_EN
        vecs.push_back('{7'b1101111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2});
`endif

        // Reset: everything low, including Instr_Ready
        #12;
        check("reset_outputs", int'(all_outs), 0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("release_ready", int'(Instr_Ready), 1);
        check("release_busy", int'(Busy), 0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back BR then I with Instr_Valid held high
        for (int i = 0; i < 50 && !Instr_Ready; i++) @(negedge CLK);
        Instr_Valid   = 1'b1;
        Decoder_Input = 7'b1100011;
        @(posedge CLK);
        #1;
        Decoder_Input = 7'b0010011;
        br_cyc = 0;
        rw_cyc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge CLK);
            if (Branch && br_cyc == 0) br_cyc = cyc;
            if (RegWrite && rw_cyc == 0) rw_cyc = cyc;
            if (cyc == 2) begin
                check("b2b_aluop_br", int'(ALUOp_MD), 1);
                check("b2b_imm_br", int'(ImmSrc), 2);
            end
            if (cyc == 3) begin
                check("b2b_ready_c3", int'(Instr_Ready), 1);
                @(posedge CLK);
                #1;
                Instr_Valid = 1'b0;
            end
            if (cyc == 4) check("b2b_busy_c4", int'(Busy), 1);
        end
        check("b2b_branch_cyc", br_cyc, 2);
        check("b2b_regwrite_cyc", rw_cyc, 6);

        // Asynchronous reset while a stalled load sits in MEM
        for (int i = 0; i < 50 && !Instr_Ready; i++) @(negedge CLK);
        Instr_Valid   = 1'b1;
        Decoder_Input = 7'b0000011;
        Stall         = 1'b1;
        @(posedge CLK);
        #1;
        Instr_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("mem_rst_pre_read", int'(MemReadCpu), 1);
        #2;
        RST = 1'b0;
        #1;
        check("mem_rst_outputs", int'(all_outs), 0);
        @(negedge CLK);
        check("mem_rst_hold_outputs", int'(all_outs), 0);
        RST = 1'b1;
        Stall = 1'b0;
        #1;
        check("mem_rst_release_ready", int'(Instr_Ready), 1);
        @(negedge CLK);
        check("mem_rst_no_request", int'(MemReadCpu), 0);
        check("mem_rst_fetch_busy", int'(Busy), 0);

        run_vec(vecs[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
